// File: rtl/dct_enc_ctrl.sv
// Forward 8x8 DCT sequencer: per (u,v) clear MAC, stream 64 pixels,
// drain the MAC pipeline, then write the coefficient at its zigzag slot.
module dct_enc_ctrl #(
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pix_rd_en,
  output logic [5:0] pix_addr,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic [2:0] u,
  output logic [2:0] v,
  output logic       mac_clr,
  output logic       mac_en,
  output logic       coef_we,
  output logic [5:0] coef_addr
);

  typedef enum logic [2:0] {
    IDLE, CLR, ACC, DRAIN, WRITE, DONE
  } state_t;

  localparam logic [3:0] DLAST =
    4'(RD_LAT + MAC_LAT - 1);

  state_t     state;
  logic [2:0] ix;
  logic [2:0] iy;
  logic [3:0] dcnt;
  logic [6:0] dly [RD_LAT];

  // JPEG zigzag index of row u, column v
  function automatic logic [5:0] zz(
    input logic [2:0] ru,
    input logic [2:0] rv
  );
    logic [6:0] d;
    logic [6:0] lo;
    logic [6:0] base;
    logic [6:0] off;
    d  = {4'd0, ru} + {4'd0, rv};
    lo = (d > 7'd7) ? d - 7'd7 : 7'd0;
    if (d < 7'd8)
      base = (d * (d + 7'd1)) >> 1;
    else
      base = 7'd64 -
        (((7'd15 - d) * (7'd16 - d)) >> 1);
    off = d[0] ? {4'd0, ru} - lo
               : {4'd0, rv} - lo;
    return 6'(base + off);
  endfunction

  assign pix_addr = {iy, ix};
  // done holds busy for its pulse cycle
  assign busy = (state != IDLE) | done;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state     <= IDLE;
      u         <= '0;
      v         <= '0;
      ix        <= '0;
      iy        <= '0;
      dcnt      <= '0;
      pix_rd_en <= 1'b0;
      mac_clr   <= 1'b0;
      coef_we   <= 1'b0;
      coef_addr <= '0;
      done      <= 1'b0;
    end else begin
      mac_clr <= 1'b0;
      coef_we <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          u <= '0;
          v <= '0;
          if (start && !done) begin
            state   <= CLR;
            mac_clr <= 1'b1;
          end
        end
        CLR: begin
          state     <= ACC;
          pix_rd_en <= 1'b1;
          ix        <= '0;
          iy        <= '0;
        end
        ACC: begin
          ix <= ix + 3'd1;
          if (ix == 3'd7)
            iy <= iy + 3'd1;
          if (ix == 3'd7 && iy == 3'd7) begin
            state     <= DRAIN;
            pix_rd_en <= 1'b0;
            dcnt      <= '0;
          end
        end
        DRAIN: begin
          if (dcnt == DLAST)
            state <= WRITE;
          else
            dcnt <= dcnt + 4'd1;
        end
        WRITE: begin
          coef_we   <= 1'b1;
          coef_addr <= zz(u, v);
          if (u == 3'd7 && v == 3'd7) begin
            state <= DONE;
          end else begin
            v <= v + 3'd1;
            if (v == 3'd7)
              u <= u + 3'd1;
            state   <= CLR;
            mac_clr <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          u     <= '0;
          v     <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // read-latency line: {rd_en, iy, ix}
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < RD_LAT; i++)
        dly[i] <= '0;
    end else begin
      dly[0] <= {pix_rd_en, iy, ix};
      for (int i = 1; i < RD_LAT; i++)
        dly[i] <= dly[i-1];
    end
  end

  assign {mac_en, y, x} = dly[RD_LAT-1];

endmodule

// File: tb/tb_dct_enc_ctrl.sv
// Bench for dct_enc_ctrl: reset/idle, full blocks, busy-start,
// mid-run reset, and a RD_LAT=3/MAC_LAT=2 instance.
module tb_dct_enc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a_rst, a_start, a_busy, a_done, a_rd;
  logic [5:0] a_pa, a_ca;
  logic [2:0] a_x, a_y, a_u, a_v;
  logic       a_clr, a_me, a_we;

  logic       b_rst, b_start, b_busy, b_done, b_rd;
  logic [5:0] b_pa, b_ca;
  logic [2:0] b_x, b_y, b_u, b_v;
  logic       b_clr, b_me, b_we;

  dct_enc_ctrl u_a (
    .clk(clk), .rst_in(a_rst), .start(a_start),
    .busy(a_busy), .done(a_done),
    .pix_rd_en(a_rd), .pix_addr(a_pa),
    .x(a_x), .y(a_y), .u(a_u), .v(a_v),
    .mac_clr(a_clr), .mac_en(a_me),
    .coef_we(a_we), .coef_addr(a_ca)
  );

  dct_enc_ctrl #(.RD_LAT(3), .MAC_LAT(2)) u_b (
    .clk(clk), .rst_in(b_rst), .start(b_start),
    .busy(b_busy), .done(b_done),
    .pix_rd_en(b_rd), .pix_addr(b_pa),
    .x(b_x), .y(b_y), .u(b_u), .v(b_v),
    .mac_clr(b_clr), .mac_en(b_me),
    .coef_we(b_we), .coef_addr(b_ca)
  );

  int checks = 0;
  int errors = 0;
  int zzt [64];
  bit sel = 1'b0;

  int we_c[$], we_a[$], done_c[$], clr_c[$];
  int iss_c[$], iss_a[$], mac_c[$], mac_a[$];
  int overlap = 0;

  logic       m_we, m_done, m_clr, m_rd, m_me;
  logic [5:0] m_ca, m_pa;
  logic [2:0] m_x, m_y;
  int         mc;

  // event log of the selected instance, cycle-numbered
  always @(negedge clk) begin
    if (sel == 1'b0) begin
      m_we = a_we; m_ca = a_ca; m_done = a_done;
      m_clr = a_clr; m_rd = a_rd; m_pa = a_pa;
      m_me = a_me; m_x = a_x; m_y = a_y;
    end else begin
      m_we = b_we; m_ca = b_ca; m_done = b_done;
      m_clr = b_clr; m_rd = b_rd; m_pa = b_pa;
      m_me = b_me; m_x = b_x; m_y = b_y;
    end
    mc = cyc + 1;
    if (m_we) begin
      we_c.push_back(mc);
      we_a.push_back(int'(m_ca));
    end
    if (m_done) done_c.push_back(mc);
    if (m_clr) clr_c.push_back(mc);
    if (m_rd) begin
      iss_c.push_back(mc);
      iss_a.push_back(int'(m_pa));
    end
    if (m_me) begin
      mac_c.push_back(mc);
      mac_a.push_back(int'({m_y, m_x}));
    end
    if (m_clr && m_me) overlap++;
  end

  task automatic chk(input string tag,
                     input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d",
               tag, obs, exp);
      $error("%s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_start(input bit s);
    if (sel == 1'b0) a_start = s;
    else b_start = s;
  endtask

  function automatic int vec_a();
    return int'({a_busy, a_done, a_rd, a_pa, a_x, a_y,
                 a_u, a_v, a_clr, a_me, a_we, a_ca});
  endfunction

  function automatic int vec_b();
    return int'({b_busy, b_done, b_rd, b_pa, b_x, b_y,
                 b_u, b_v, b_clr, b_me, b_we, b_ca});
  endfunction

  task automatic clear_logs();
    we_c.delete(); we_a.delete(); done_c.delete();
    clr_c.delete(); iss_c.delete(); iss_a.delete();
    mac_c.delete(); mac_a.delete();
    overlap = 0;
  endtask

  // zigzag table from walking the anti-diagonals in scan order
  task automatic build_zz();
    int idx, uu, vv;
    idx = 0;
    for (int d = 0; d < 15; d++)
      for (int t = 0; t <= d; t++) begin
        uu = (d % 2 == 1) ? t : d - t;
        vv = d - uu;
        if (uu < 8 && vv < 8) begin
          zzt[uu*8 + vv] = idx;
          idx++;
        end
      end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic pulse_start(output int k);
    set_start(1'b1);
    k = cyc + 1;
  endtask

  // runs until busy falls; re-pulses start while busy
  task automatic run_block(input int k, output int fell);
    int kr;
    kr = k + 2 + int'($urandom_range(4200));
    fell = -1;
    for (int i = 0; i < 6000; i++) begin
      tick();
      set_start((cyc + 1 == k + 500) || (cyc + 1 == kr));
      if (!(sel ? b_busy : a_busy)) begin
        fell = cyc + 1;
        break;
      end
    end
    set_start(1'b0);
  endtask

  task automatic check_block(input string tg, input int k,
                             input int R, input int M);
    int p, w0, bad, n, j;
    int lst [10];
    lst = '{0, 1, 5, 6, 14, 15, 27, 28, 2, 4};
    p  = 66 + R + M;
    w0 = k + 67 + R + M;
    chk({tg, "_we_count"}, we_c.size(), 64);
    chk({tg, "_we_first"}, qat(we_c, 0), w0);
    chk({tg, "_we_last"}, qat(we_c, 63), w0 + 63*p);
    bad = 0;
    for (int i = 0; i < we_c.size() && i < 64; i++)
      if (we_c[i] != w0 + i*p) bad++;
    chk({tg, "_we_timing_bad"}, bad, 0);
    bad = 0;
    for (int i = 0; i < we_a.size() && i < 64; i++)
      if (we_a[i] != zzt[i]) bad++;
    chk({tg, "_we_addr_bad"}, bad, 0);
    bad = 0;
    for (int i = 0; i < 10; i++)
      if (qat(we_a, i) != lst[i]) bad++;
    chk({tg, "_addr_head_bad"}, bad, 0);
    chk({tg, "_addr_last"}, qat(we_a, 63), 63);
    chk({tg, "_done_count"}, done_c.size(), 1);
    chk({tg, "_done_cyc"}, qat(done_c, 0), w0 + 63*p + 1);
    chk({tg, "_clr_count"}, clr_c.size(), 64);
    bad = 0;
    for (int i = 0; i < clr_c.size() && i < 64; i++)
      if (clr_c[i] != k + 1 + i*p) bad++;
    chk({tg, "_clr_timing_bad"}, bad, 0);
    chk({tg, "_iss_count"}, iss_c.size(), 4096);
    bad = 0;
    for (int i = 0; i < iss_c.size() && i < 4096; i++) begin
      n = i / 64;
      j = i % 64;
      if (iss_c[i] != k + 2 + n*p + j || iss_a[i] != j)
        bad++;
    end
    chk({tg, "_iss_bad"}, bad, 0);
    chk({tg, "_mac_count"}, mac_c.size(), 4096);
    chk({tg, "_mac_first"}, qat(mac_c, 0), k + 2 + R);
    bad = 0;
    for (int i = 0; i < mac_c.size() && i < 4096; i++) begin
      n = i / 64;
      j = i % 64;
      if (mac_c[i] != k + 2 + R + n*p + j || mac_a[i] != j)
        bad++;
    end
    chk({tg, "_mac_align_bad"}, bad, 0);
    chk({tg, "_clr_mac_overlap"}, overlap, 0);
  endtask

  initial begin
    int k, k2, k3, fell, rc, gap;
    a_rst = 1'b1; b_rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0;
    build_zz();

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_a", vec_a(), 0);
      chk("reset_b", vec_b(), 0);
    end
    a_rst = 1'b0; b_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_a", vec_a(), 0);
      chk("idle_b", vec_b(), 0);
    end

    sel = 1'b0;
    clear_logs();
    gap = int'($urandom_range(1, 5));
    for (int i = 0; i < gap; i++) tick();
    pulse_start(k);
    run_block(k, fell);
    check_block("a1", k, 1, 1);
    chk("a1_busy_fall", fell, k + 4355);

    clear_logs();
    pulse_start(k2);
    rc = k2 + 2 + 680 + int'($urandom_range(63));
    for (int i = 0; i < 2000 && cyc + 1 < rc; i++) begin
      tick();
      set_start(1'b0);
    end
    chk("rst_reach", cyc + 1, rc);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    chk("rst_outputs", vec_a(), 0);
    chk("rst_b2b_first_clr", qat(clr_c, 0), k2 + 1);
    chk("rst_we_before", we_c.size(), 10);
    chk("rst_clr_before", clr_c.size(), 11);
    for (int i = 0; i < 150; i++) tick();
    chk("rst_we_after", we_c.size(), 10);
    chk("rst_done_after", done_c.size(), 0);
    chk("rst_busy_after", int'(a_busy), 0);

    clear_logs();
    gap = int'($urandom_range(1, 5));
    for (int i = 0; i < gap; i++) tick();
    pulse_start(k3);
    run_block(k3, fell);
    check_block("a2", k3, 1, 1);
    chk("a2_busy_fall", fell, k3 + 4355);

    tick();
    sel = 1'b1;
    clear_logs();
    gap = int'($urandom_range(1, 5));
    for (int i = 0; i < gap; i++) tick();
    pulse_start(k);
    run_block(k, fell);
    check_block("b", k, 3, 2);
    chk("b_busy_fall", fell, k + 72 + 63*71 + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
